// File: rtl/rtc_mode_sequencer.sv
// RTC transaction sequencer: fixed-priority request arbitration (Inicio > Escribir > ProgramarCrono)
// with periodic background reads, one start/done handshake per launch, bus timeout abort.
module rtc_mode_sequencer #(
   parameter int READ_PERIOD = 256,
   parameter int PERIOD_W    = 12,
   parameter int TIMEOUT     = 1023,
   parameter int TO_W        = 10
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       Inicio,
   input  logic       Escribir,
   input  logic       ProgramarCrono,
   input  logic       bus_done,
   output logic       bus_start,
   output logic       RW,
   output logic       Crono,
   output logic       Per_read,
   output logic [1:0] mode,
   output logic       busy,
   output logic       timeout_err
);
   localparam logic [PERIOD_W-1:0] PER_MAX = PERIOD_W'(READ_PERIOD - 1);
   localparam logic [TO_W-1:0]     TO_MAX  = TO_W'(TIMEOUT - 1);
   localparam logic [1:0] M_INIT  = 2'b00;
   localparam logic [1:0] M_WRITE = 2'b01;
   localparam logic [1:0] M_CRONO = 2'b10;
   localparam logic [1:0] M_PER   = 2'b11;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic [1:0]          mode_q, mode_d;
   logic                start_q, start_d;
   logic                busy_q, busy_d;
   logic                rw_q, rw_d;
   logic                crono_q, crono_d;
   logic                per_q, per_d;
   logic                terr_q, terr_d;
   logic                launch;
   logic [1:0]          sel;

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      to_d     = to_q;
      mode_d   = mode_q;
      start_d  = 1'b0;
      busy_d   = busy_q;
      rw_d     = rw_q;
      crono_d  = crono_q;
      per_d    = per_q;
      terr_d   = 1'b0;
      launch   = 1'b0;
      sel      = M_PER;
      case (state_q)
         S_IDLE: begin
            if (period_q != PER_MAX) period_d = period_q + 1'b1;
            // requests are only looked at here, so anything raised while busy is dropped
            if (Inicio) begin
               launch = 1'b1;
               sel    = M_INIT;
            end else if (Escribir) begin
               launch = 1'b1;
               sel    = M_WRITE;
            end else if (ProgramarCrono) begin
               launch = 1'b1;
               sel    = M_CRONO;
            end else if (period_q == PER_MAX) begin
               launch = 1'b1;
               sel    = M_PER;
            end
            if (launch) begin
               state_d = S_ISSUE;
               start_d = 1'b1;
               busy_d  = 1'b1;
               mode_d  = sel;
               rw_d    = (sel == M_PER);
               crono_d = (sel == M_CRONO);
               per_d   = (sel == M_PER);
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            to_d    = '0;
         end
         S_WAIT: begin
            // a completion landing on the last allowed cycle wins over the timeout
            if (bus_done || (to_q == TO_MAX)) begin
               state_d  = S_IDLE;
               period_d = '0;
               busy_d   = 1'b0;
               rw_d     = 1'b0;
               crono_d  = 1'b0;
               per_d    = 1'b0;
               terr_d   = !bus_done;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            period_d = '0;
            to_d     = '0;
            busy_d   = 1'b0;
            rw_d     = 1'b0;
            crono_d  = 1'b0;
            per_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         period_q <= '0;
         to_q     <= '0;
         mode_q   <= M_INIT;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         rw_q     <= 1'b0;
         crono_q  <= 1'b0;
         per_q    <= 1'b0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         to_q     <= to_d;
         mode_q   <= mode_d;
         start_q  <= start_d;
         busy_q   <= busy_d;
         rw_q     <= rw_d;
         crono_q  <= crono_d;
         per_q    <= per_d;
         terr_q   <= terr_d;
      end
   end

   assign bus_start   = start_q;
   assign busy        = busy_q;
   assign RW          = rw_q;
   assign Crono       = crono_q;
   assign Per_read    = per_q;
   assign mode        = mode_q;
   assign timeout_err = terr_q;
endmodule

// File: tb/tb_rtc_mode_sequencer.sv
// Bench for rtc_mode_sequencer: timeline reference model pushes expected start/end/timeout
// events into a queue; an independent monitor compares them against the DUT every cycle.
module tb_rtc_mode_sequencer;
   localparam int RP = 8;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Inicio = 1'b0, Escribir = 1'b0, ProgramarCrono = 1'b0, bus_done = 1'b0;
   logic       bus_start, RW, Crono, Per_read, busy, timeout_err;
   logic [1:0] mode;

   rtc_mode_sequencer #(.READ_PERIOD(RP), .PERIOD_W(4), .TIMEOUT(TO), .TO_W(5)) dut (
      .clk(clk), .Reset(Reset), .Inicio(Inicio), .Escribir(Escribir),
      .ProgramarCrono(ProgramarCrono), .bus_done(bus_done), .bus_start(bus_start),
      .RW(RW), .Crono(Crono), .Per_read(Per_read), .mode(mode), .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      int         cyc;
      int         kind;   // 0 start, 1 end of busy, 2 timeout pulse
      logic [4:0] f;      // {mode, RW, Crono, Per_read}
   } ev_t;
   ev_t evq[$];

   int n_assert = 0;
   int n_fail   = 0;

   // timeline model: the DUT is idle from m_free_at on; idle run started at m_idle_start
   int m_free_at, m_idle_start, m_done_cyc, m_issue_cyc;
   int phase;
   bit crono_go;

   function automatic logic [4:0] fld(input logic [1:0] md);
      return {md, md == 2'b11, md == 2'b10, md == 2'b11};
   endfunction

   task automatic check_zero(input string name);
      logic [7:0] got;
      got = {bus_start, RW, Crono, Per_read, mode, busy, timeout_err};
      n_assert++;
      if (got !== 8'h00) begin
         n_fail++;
         $display("FAIL %s: outputs {start,RW,Crono,Per,mode,busy,terr}=%b, required 00000000", name, got);
      end
   endtask

   // decide inputs for the next edge and predict the DUT response from the timeline
   task automatic step();
      int c, k, n, s, r, m;
      bit idle;
      logic [2:0] req;
      logic bd;
      c = edge_cnt;
      idle = (c >= m_free_at);
      req = 3'b000;
      bd = 1'b0;
      m = -1;
      case (phase)
         1: if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(1, 7));
         2, 7: req = 3'b001;
         3: req[2] = idle && (c - m_idle_start == RP - 1) && ($urandom_range(0, 1) == 1);
         5: if ($urandom_range(0, 2) == 0) req = 3'($urandom_range(1, 7));
         default: req = 3'b000;
      endcase
      case (phase)
         1: k = $urandom_range(1, 5);
         2: k = 1;
         4, 7: k = 0;
         5: begin
            r = $urandom_range(0, 5);
            case (r)
               0: k = 1;
               1: k = 2;
               2: k = TO;
               3: k = 0;
               default: begin
                  k = $urandom_range(1, 20);
                  if (k > TO) k = 0;
               end
            endcase
         end
         default: k = 2;
      endcase
      if (c == m_done_cyc) bd = 1'b1;
      else if ((phase == 4 || phase == 5) && (idle || c == m_issue_cyc) && $urandom_range(0, 3) == 0)
         bd = 1'b1;
      if (idle) begin
         if (req[2]) m = 0;
         else if (req[1]) m = 1;
         else if (req[0]) m = 2;
         else if (c - m_idle_start == RP - 1) m = 3;
         if (m >= 0) begin
            s = c + 1;
            n = (k == 0) ? TO : k;
            evq.push_back('{s, 0, fld(2'(m))});
            evq.push_back('{s + n + 1, 1, 5'b0});
            if (k == 0) evq.push_back('{s + n + 1, 2, 5'b0});
            m_issue_cyc  = s;
            m_done_cyc   = (k == 0) ? -1 : s + k;
            m_free_at    = s + n + 1;
            m_idle_start = s + n + 1;
            if (m == 2) crono_go = 1'b1;
         end
      end
      Inicio = req[2];
      Escribir = req[1];
      ProgramarCrono = req[0];
      bus_done = bd;
   endtask

   task automatic release_reset();
      Reset = 1'b0;
      m_free_at = edge_cnt;
      m_idle_start = edge_cnt;
      m_issue_cyc = -1;
   endtask

   // monitor
   initial begin
      logic       busy_prev;
      logic [4:0] cur, f_exp, want, got;
      logic [2:0] obs, expv;
      ev_t ev;
      int c;
      busy_prev = 1'b0;
      cur = 5'b0;
      forever begin
         @(posedge clk);
         #1;
         if (Reset) begin
            busy_prev = 1'b0;
            cur = 5'b0;
         end else begin
            c = edge_cnt;
            expv = 3'b000;
            f_exp = cur;
            while (evq.size() > 0 && evq[0].cyc <= c) begin
               ev = evq.pop_front();
               expv[2 - ev.kind] = 1'b1;
               if (ev.kind == 0) f_exp = ev.f;
            end
            obs = {bus_start, busy_prev & ~busy, timeout_err};
            if (obs != 3'b000 || expv != 3'b000) begin
               n_assert++;
               if (obs !== expv) begin
                  n_fail++;
                  $display("FAIL events @%0d: {start,end,terr} got %b, required %b", c, obs, expv);
               end
            end
            if (expv[2]) cur = f_exp;
            want = busy ? cur : {cur[4:3], 3'b000};
            got = {mode, RW, Crono, Per_read};
            n_assert++;
            if (got !== want) begin
               n_fail++;
               $display("FAIL outputs @%0d: {mode,RW,Crono,Per} got %b, required %b", c, got, want);
            end
            busy_prev = busy;
         end
      end
   end

   // stimulus
   initial begin
      int guard;
      m_done_cyc = -1;
      m_issue_cyc = -1;
      crono_go = 1'b0;
      phase = 0;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      release_reset();
      step();
      repeat (40) begin @(negedge clk); step(); end
      phase = 1;
      repeat (80) begin @(negedge clk); step(); end
      phase = 2;
      repeat (30) begin @(negedge clk); step(); end
      phase = 3;
      repeat (60) begin @(negedge clk); step(); end
      phase = 4;
      repeat (60) begin @(negedge clk); step(); end
      phase = 5;
      repeat (400) begin @(negedge clk); step(); end

      phase = 7;
      crono_go = 1'b0;
      guard = 0;
      do begin
         @(negedge clk);
         step();
         guard++;
      end while (!crono_go && guard < 60);
      phase = 8;
      repeat (6) begin @(negedge clk); step(); end
      @(negedge clk);
      Reset = 1'b1;
      Inicio = 1'b0;
      Escribir = 1'b0;
      ProgramarCrono = 1'b0;
      bus_done = 1'b0;
      #1;
      check_zero("async_reset_mid_wait");
      evq.delete();
      m_done_cyc = -1;
      repeat (3) @(negedge clk);
      check_zero("held_in_reset");
      release_reset();
      m_done_cyc = edge_cnt + 2;
      phase = 9;
      step();
      repeat (40) begin @(negedge clk); step(); end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/rtc_mode_sequencer.md
Name: rtc_mode_sequencer

Overview:
Parametrised transaction sequencer for the RTC control path. It arbitrates between three requests: init-write (Inicio), user write (Escribir) and timer programming (ProgramarCrono). When none is pending, it issues periodic background reads. Each request is launched as a single start/done handshake towards the bus transaction engine, with a configurable read period, a bus timeout and error reporting. It sits between the user-input/debounce logic and the RTC bus protocol engine.

Parameters:
READ_PERIOD, 256, idle cycles between periodic reads (>=2)
PERIOD_W, 12, width of period counter (2^PERIOD_W > READ_PERIOD)
TIMEOUT, 1023, max cycles in WAIT before abort (>=1)
TO_W, 10, width of timeout counter (2^TO_W > TIMEOUT)

Ports:
clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Inicio  in  1  init-write request, level
Escribir  in  1  user write request, level
ProgramarCrono  in  1  timer-programming request, level
bus_done  in  1  one-cycle completion pulse from bus engine
bus_start  out  1  one-cycle launch pulse to bus engine
RW  out  1  1 = read protocol, 0 = write protocol; valid while busy
Crono  out  1  1 = timer-programming transaction; valid while busy
Per_read  out  1  1 = periodic read in progress
mode  out  2  00 init, 01 write, 10 crono, 11 periodic read; holds last launched value
busy  out  1  high in ISSUE and WAIT
timeout_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset is asynchronous, active-high; clock is clk. While Reset is high: state IDLE, both counters 0, all outputs 0 (mode=00).
- Reset mid-transaction aborts immediately. No bus_start or timeout_err is generated on release.
- All outputs are registered.
- States:
  - IDLE: busy=0, RW=Crono=Per_read=0. period_cnt increments and saturates at READ_PERIOD-1.
  - ISSUE: exactly 1 cycle; bus_start=1.
  - WAIT: until bus_done or timeout.
- IDLE->ISSUE when a request is sampled high, using fixed priority Inicio > Escribir > ProgramarCrono.
  - Otherwise IDLE->ISSUE with periodic read when period_cnt == READ_PERIOD-1.
  - A pending request beats the periodic read in the same cycle.
- Selection latency: request sampled at edge N -> bus_start, busy, RW, Crono, Per_read and mode all updated at edge N+1.
- Per-mode outputs in ISSUE/WAIT:
  - init: RW=0, Crono=0
  - write: RW=0, Crono=0
  - crono: RW=0, Crono=1
  - periodic: RW=1, Per_read=1
- Request inputs are ignored (not latched) while busy. A level still high on return to IDLE relaunches after exactly 1 IDLE cycle.
- ISSUE->WAIT unconditionally. to_cnt clears on entry to WAIT and increments each WAIT cycle.
- WAIT->IDLE on bus_done. On that edge: period_cnt=0, busy=0.
- WAIT->IDLE on to_cnt == TIMEOUT-1 without bus_done. timeout_err=1 for 1 cycle on entry to IDLE; period_cnt=0.
  - bus_done in the same cycle as the timeout condition: done wins, no error.
- bus_done in IDLE or ISSUE is ignored.
- Minimum spacing between consecutive bus_start pulses: 3 cycles (ISSUE, WAIT>=1, IDLE>=1).
- No illegal state is reachable. The default branch forces IDLE.

Test Plan:
(Bench uses READ_PERIOD=8, TIMEOUT=16.)
- Reset, all requests low, bus_done returned 2 cycles after each start -> bus_start every 8+1+2=11 cycles; mode=11, RW=1, Per_read=1 while busy.
- Escribir and ProgramarCrono pulsed high together for 1 cycle in IDLE -> one launch with mode=01, RW=0, Crono=0. ProgramarCrono is lost and not launched.
- ProgramarCrono held high, done after 1 WAIT cycle -> repeated launches 3 cycles apart, each with mode=10, Crono=1, RW=0. No periodic read occurs.
- Inicio raised in the same cycle that period_cnt reaches 7 -> launch mode=00; periodic read deferred until 8 idle cycles after completion.
- bus_done never returned -> busy for 17 cycles (ISSUE+16 WAIT), then a timeout_err pulse of 1 cycle; next periodic read 8 cycles later. bus_done coinciding with the 16th WAIT cycle -> no timeout_err.
- Reset asserted mid-WAIT of a crono transaction -> all outputs 0 asynchronously. After release, first launch is a periodic read after 8 cycles; a late bus_done arriving during IDLE is ignored.
